// File: rtl/sy_dcache_refill.sv
// Data-cache miss handler: optional dirty-victim writeback, then line fill and tag update.
// Drives the low-priority tag/data port of the dcache memory and an AXI-like memory side.

package sy_dcache_pkg;
  localparam int unsigned DCACHE_WAY_NUM   = 4;
  localparam int unsigned DCACHE_SET_WTH   = 6;
  localparam int unsigned DCACHE_BLOCK_WTH = 6;
  localparam int unsigned DCACHE_DATA_WTH  = 3;
  localparam int unsigned DCACHE_IDX_WTH   = DCACHE_SET_WTH + DCACHE_BLOCK_WTH;
  localparam int unsigned DCACHE_TAG_WTH   = 64 - DCACHE_IDX_WTH;

  typedef enum logic [1:0] {
    Clean     = 2'd0,
    Shared    = 2'd1,
    Exclusive = 2'd2,
    Dirty     = 2'd3
  } cache_state_e;

  typedef struct packed {
    logic                      valid;
    cache_state_e              state;
    logic [DCACHE_TAG_WTH-1:0] tag;
  } tag_data_t;

  typedef struct packed {
    logic                      we;
    logic [DCACHE_IDX_WTH-1:0] idx;
    logic [DCACHE_WAY_NUM-1:0] way_en;
    tag_data_t                 wr_tag;
  } tag_req_t;

  typedef struct packed {
    tag_data_t [DCACHE_WAY_NUM-1:0] tag_data;
  } tag_rsp_t;

  typedef struct packed {
    logic                      we;
    logic [DCACHE_IDX_WTH-1:0] idx;
    logic [DCACHE_WAY_NUM-1:0] way_en;
    logic [7:0]                wstrb;
    logic [63:0]               wr_data;
  } data_req_t;

  typedef struct packed {
    logic [DCACHE_WAY_NUM-1:0][63:0] rd_data;
  } data_rsp_t;
endpackage

module sy_dcache_refill
  import sy_dcache_pkg::*;
#(
  parameter int unsigned ADDR_WTH = 64,
  parameter int unsigned BEATS    = 2**(DCACHE_BLOCK_WTH-DCACHE_DATA_WTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      miss_req_i,
  output logic                      miss_gnt_o,
  input  logic [ADDR_WTH-1:0]       miss_addr_i,
  input  logic [DCACHE_WAY_NUM-1:0] miss_way_i,
  input  cache_state_e              fill_state_i,
  output logic                      miss_done_o,
  output logic                      busy_o,
  output logic                      tag_req_o,
  input  logic                      tag_gnt_i,
  output tag_req_t                  tag_req_bits_o,
  input  tag_rsp_t                  tag_rsp_bits_i,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output data_req_t                 data_req_bits_o,
  input  data_rsp_t                 data_rsp_bits_i,
  output logic                      mem_ar_valid_o,
  input  logic                      mem_ar_ready_i,
  output logic [ADDR_WTH-1:0]       mem_ar_addr_o,
  input  logic                      mem_r_valid_i,
  input  logic [63:0]               mem_r_data_i,
  input  logic                      mem_r_last_i,
  output logic                      mem_aw_valid_o,
  input  logic                      mem_aw_ready_i,
  output logic [ADDR_WTH-1:0]       mem_aw_addr_o,
  output logic                      mem_w_valid_o,
  input  logic                      mem_w_ready_i,
  output logic [63:0]               mem_w_data_o,
  output logic                      mem_w_last_o,
  input  logic                      mem_b_valid_i
);

  localparam int unsigned CNT_WTH     = $clog2(BEATS);
  localparam int unsigned WAY_IDX_WTH = $clog2(DCACHE_WAY_NUM);
  localparam int unsigned OFF_WTH     = DCACHE_BLOCK_WTH;
  localparam logic [ADDR_WTH-1:0] OFF_MASK = ADDR_WTH'((64'd1 << OFF_WTH) - 64'd1);

  typedef enum logic [3:0] {
    IDLE, TAG_RD, TAG_CHK, WB_RD, WB_CAP, WB_AW, WB_W, WB_B,
    FILL_AR, FILL_R, FILL_WR, TAG_WR
  } state_e;

  state_e                    state_q;
  logic [ADDR_WTH-1:0]       addr_q;
  logic [DCACHE_WAY_NUM-1:0] way_q;
  cache_state_e              fill_state_q;
  logic [DCACHE_TAG_WTH-1:0] vic_tag_q;
  logic [CNT_WTH-1:0]        cnt_q;
  logic [63:0]               line_q [BEATS];

  logic [ADDR_WTH-1:0]       miss_line_c;
  logic [WAY_IDX_WTH-1:0]    way_idx_c;
  logic [DCACHE_SET_WTH-1:0] set_c;
  logic [CNT_WTH-1:0]        cnt_inc_c;
  logic                      cnt_last_c;
  tag_data_t                 vic_c;

  function automatic logic [WAY_IDX_WTH-1:0] onehot_idx(input logic [DCACHE_WAY_NUM-1:0] oh);
    logic [WAY_IDX_WTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < DCACHE_WAY_NUM; i++) begin
      if (oh[i]) idx = WAY_IDX_WTH'(i);
    end
    return idx;
  endfunction

  function automatic logic [DCACHE_IDX_WTH-1:0] beat_idx(input logic [DCACHE_SET_WTH-1:0] set,
                                                         input logic [CNT_WTH-1:0] beat);
    return DCACHE_IDX_WTH'({set, beat, DCACHE_DATA_WTH'(0)});
  endfunction

  function automatic tag_req_t mk_tag_req(input logic we, input logic [DCACHE_IDX_WTH-1:0] idx,
                                          input logic [DCACHE_WAY_NUM-1:0] way,
                                          input tag_data_t td);
    tag_req_t r;
    r        = '0;
    r.we     = we;
    r.idx    = idx;
    r.way_en = way;
    r.wr_tag = td;
    return r;
  endfunction

  function automatic data_req_t mk_data_req(input logic we, input logic [DCACHE_IDX_WTH-1:0] idx,
                                            input logic [DCACHE_WAY_NUM-1:0] way,
                                            input logic [63:0] wdata);
    data_req_t r;
    r        = '0;
    r.we     = we;
    r.idx    = idx;
    r.way_en = way;
    if (we) begin
      r.wstrb   = 8'hFF;
      r.wr_data = wdata;
    end
    return r;
  endfunction

  assign miss_line_c = miss_addr_i & ~OFF_MASK;
  assign way_idx_c   = onehot_idx(way_q);
  assign set_c       = addr_q[DCACHE_IDX_WTH-1:DCACHE_BLOCK_WTH];
  assign cnt_inc_c   = cnt_q + 1'b1;
  assign cnt_last_c  = (cnt_q == CNT_WTH'(BEATS-1));
  assign vic_c       = tag_rsp_bits_i.tag_data[way_idx_c];

  // Held off in the miss_done_o cycle so a new miss starts strictly after completion.
  assign miss_gnt_o = rst_i && (state_q == IDLE) && miss_req_i && !miss_done_o;

  // Single-process FSM; every port output is a flop updated on the transition into its state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      way_q           <= '0;
      fill_state_q    <= Clean;
      vic_tag_q       <= '0;
      cnt_q           <= '0;
      for (int i = 0; i < BEATS; i++) line_q[i] <= '0;
      busy_o          <= 1'b0;
      miss_done_o     <= 1'b0;
      tag_req_o       <= 1'b0;
      tag_req_bits_o  <= '0;
      data_req_o      <= 1'b0;
      data_req_bits_o <= '0;
      mem_ar_valid_o  <= 1'b0;
      mem_ar_addr_o   <= '0;
      mem_aw_valid_o  <= 1'b0;
      mem_aw_addr_o   <= '0;
      mem_w_valid_o   <= 1'b0;
      mem_w_data_o    <= '0;
      mem_w_last_o    <= 1'b0;
    end else begin
      miss_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_gnt_o) begin
            addr_q         <= miss_line_c;
            way_q          <= miss_way_i;
            fill_state_q   <= fill_state_i;
            busy_o         <= 1'b1;
            tag_req_o      <= 1'b1;
            tag_req_bits_o <= mk_tag_req(1'b0, DCACHE_IDX_WTH'(miss_line_c), miss_way_i, '0);
            state_q        <= TAG_RD;
          end
        end
        TAG_RD: begin
          if (tag_gnt_i) begin
            tag_req_o      <= 1'b0;
            tag_req_bits_o <= '0;
            state_q        <= TAG_CHK;
          end
        end
        TAG_CHK: begin
          if (vic_c.valid && (vic_c.state == Dirty)) begin
            vic_tag_q       <= vic_c.tag;
            cnt_q           <= '0;
            data_req_o      <= 1'b1;
            data_req_bits_o <= mk_data_req(1'b0, beat_idx(set_c, '0), way_q, '0);
            state_q         <= WB_RD;
          end else begin
            mem_ar_valid_o  <= 1'b1;
            mem_ar_addr_o   <= addr_q;
            state_q         <= FILL_AR;
          end
        end
        WB_RD: begin
          if (data_gnt_i) begin
            data_req_o      <= 1'b0;
            data_req_bits_o <= '0;
            state_q         <= WB_CAP;
          end
        end
        WB_CAP: begin
          line_q[cnt_q] <= data_rsp_bits_i.rd_data[way_idx_c];
          if (cnt_last_c) begin
            cnt_q          <= '0;
            mem_aw_valid_o <= 1'b1;
            mem_aw_addr_o  <= ADDR_WTH'({vic_tag_q, set_c, OFF_WTH'(0)});
            state_q        <= WB_AW;
          end else begin
            cnt_q           <= cnt_inc_c;
            data_req_o      <= 1'b1;
            data_req_bits_o <= mk_data_req(1'b0, beat_idx(set_c, cnt_inc_c), way_q, '0);
            state_q         <= WB_RD;
          end
        end
        WB_AW: begin
          if (mem_aw_ready_i) begin
            mem_aw_valid_o <= 1'b0;
            mem_aw_addr_o  <= '0;
            mem_w_valid_o  <= 1'b1;
            mem_w_data_o   <= line_q[cnt_q];
            mem_w_last_o   <= cnt_last_c;
            state_q        <= WB_W;
          end
        end
        WB_W: begin
          if (mem_w_ready_i) begin
            if (cnt_last_c) begin
              cnt_q         <= '0;
              mem_w_valid_o <= 1'b0;
              mem_w_data_o  <= '0;
              mem_w_last_o  <= 1'b0;
              state_q       <= WB_B;
            end else begin
              cnt_q         <= cnt_inc_c;
              mem_w_data_o  <= line_q[cnt_inc_c];
              mem_w_last_o  <= (cnt_inc_c == CNT_WTH'(BEATS-1));
            end
          end
        end
        WB_B: begin
          if (mem_b_valid_i) begin
            mem_ar_valid_o <= 1'b1;
            mem_ar_addr_o  <= addr_q;
            state_q        <= FILL_AR;
          end
        end
        FILL_AR: begin
          if (mem_ar_ready_i) begin
            mem_ar_valid_o <= 1'b0;
            mem_ar_addr_o  <= '0;
            cnt_q          <= '0;
            state_q        <= FILL_R;
          end
        end
        FILL_R: begin
          if (mem_r_valid_i) begin
            line_q[cnt_q] <= mem_r_data_i;
            if (mem_r_last_i) begin
              // Beat 0 may be landing in this same cycle on a single-beat burst.
              cnt_q           <= '0;
              data_req_o      <= 1'b1;
              data_req_bits_o <= mk_data_req(1'b1, beat_idx(set_c, '0), way_q,
                                             (cnt_q == '0) ? mem_r_data_i : line_q[0]);
              state_q         <= FILL_WR;
            end else begin
              cnt_q <= cnt_inc_c;
            end
          end
        end
        FILL_WR: begin
          if (data_gnt_i) begin
            if (cnt_last_c) begin
              cnt_q           <= '0;
              data_req_o      <= 1'b0;
              data_req_bits_o <= '0;
              tag_req_o       <= 1'b1;
              tag_req_bits_o  <= mk_tag_req(1'b1, DCACHE_IDX_WTH'(addr_q), way_q,
                                            '{valid: 1'b1, state: fill_state_q,
                                              tag: DCACHE_TAG_WTH'(addr_q >> DCACHE_IDX_WTH)});
              state_q         <= TAG_WR;
            end else begin
              cnt_q           <= cnt_inc_c;
              data_req_bits_o <= mk_data_req(1'b1, beat_idx(set_c, cnt_inc_c), way_q,
                                             line_q[cnt_inc_c]);
            end
          end
        end
        TAG_WR: begin
          if (tag_gnt_i) begin
            tag_req_o      <= 1'b0;
            tag_req_bits_o <= '0;
            miss_done_o    <= 1'b1;
            busy_o         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sy_dcache_refill.sv
// Directed bench for sy_dcache_refill: clean/dirty misses, port stalls, W backpressure,
// early fill end, mid-fill reset and back-to-back misses.

module tb_sy_dcache_refill;
  import sy_dcache_pkg::*;

  localparam int unsigned BEATS = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         miss_req_i;
  logic         miss_gnt_o;
  logic [63:0]  miss_addr_i;
  logic [3:0]   miss_way_i;
  cache_state_e fill_state_i;
  logic         miss_done_o;
  logic         busy_o;
  logic         tag_req_o;
  logic         tag_gnt_i;
  tag_req_t     tag_req_bits_o;
  tag_rsp_t     tag_rsp_bits_i;
  logic         data_req_o;
  logic         data_gnt_i;
  data_req_t    data_req_bits_o;
  data_rsp_t    data_rsp_bits_i;
  logic         mem_ar_valid_o;
  logic         mem_ar_ready_i;
  logic [63:0]  mem_ar_addr_o;
  logic         mem_r_valid_i;
  logic [63:0]  mem_r_data_i;
  logic         mem_r_last_i;
  logic         mem_aw_valid_o;
  logic         mem_aw_ready_i;
  logic [63:0]  mem_aw_addr_o;
  logic         mem_w_valid_o;
  logic         mem_w_ready_i;
  logic [63:0]  mem_w_data_o;
  logic         mem_w_last_o;
  logic         mem_b_valid_i;

  int n_pass = 0;
  int n_chk  = 0;

  sy_dcache_refill dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_req_i(miss_req_i), .miss_gnt_o(miss_gnt_o), .miss_addr_i(miss_addr_i),
    .miss_way_i(miss_way_i), .fill_state_i(fill_state_i), .miss_done_o(miss_done_o),
    .busy_o(busy_o),
    .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i), .tag_req_bits_o(tag_req_bits_o),
    .tag_rsp_bits_i(tag_rsp_bits_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_req_bits_o(data_req_bits_o),
    .data_rsp_bits_i(data_rsp_bits_i),
    .mem_ar_valid_o(mem_ar_valid_o), .mem_ar_ready_i(mem_ar_ready_i), .mem_ar_addr_o(mem_ar_addr_o),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_data_i(mem_r_data_i), .mem_r_last_i(mem_r_last_i),
    .mem_aw_valid_o(mem_aw_valid_o), .mem_aw_ready_i(mem_aw_ready_i), .mem_aw_addr_o(mem_aw_addr_o),
    .mem_w_valid_o(mem_w_valid_o), .mem_w_ready_i(mem_w_ready_i), .mem_w_data_o(mem_w_data_o),
    .mem_w_last_o(mem_w_last_o), .mem_b_valid_i(mem_b_valid_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_tag_req"},  128'(tag_req_o),      128'(0));
    chk({tag, "_data_req"}, 128'(data_req_o),     128'(0));
    chk({tag, "_ar"},       128'(mem_ar_valid_o), 128'(0));
    chk({tag, "_aw"},       128'(mem_aw_valid_o), 128'(0));
    chk({tag, "_w"},        128'(mem_w_valid_o),  128'(0));
    chk({tag, "_done"},     128'(miss_done_o),    128'(0));
    chk({tag, "_gnt"},      128'(miss_gnt_o),     128'(0));
    chk({tag, "_busy"},     128'(busy_o),         128'(0));
  endtask

  function automatic tag_req_t exp_tag_rd(input logic [63:0] a, input logic [3:0] way);
    tag_req_t r;
    r        = '0;
    r.idx    = {a[11:6], 6'b0};
    r.way_en = way;
    return r;
  endfunction

  function automatic tag_req_t exp_tag_wr(input logic [63:0] a, input logic [3:0] way,
                                          input cache_state_e st);
    tag_req_t r;
    r              = '0;
    r.we           = 1'b1;
    r.idx          = {a[11:6], 6'b0};
    r.way_en       = way;
    r.wr_tag.valid = 1'b1;
    r.wr_tag.state = st;
    r.wr_tag.tag   = a[63:12];
    return r;
  endfunction

  function automatic data_req_t exp_data(input logic we, input logic [63:0] a, input logic [3:0] way,
                                         input int k, input logic [63:0] d);
    logic [2:0] beat;
    data_req_t  r;
    beat     = 3'(k);
    r        = '0;
    r.we     = we;
    r.idx    = {a[11:6], beat, 3'b000};
    r.way_en = way;
    if (we) begin
      r.wstrb   = 8'hFF;
      r.wr_data = d;
    end
    return r;
  endfunction

  // Non-victim ways look valid+dirty so a wrong way select would trigger a writeback.
  function automatic tag_rsp_t victim_rsp(input logic [3:0] way, input logic vld,
                                          input cache_state_e st, input logic [51:0] tag);
    tag_rsp_t r;
    for (int i = 0; i < 4; i++) begin
      r.tag_data[i].valid = 1'b1;
      r.tag_data[i].state = Dirty;
      r.tag_data[i].tag   = 52'h77;
      if (way[i]) begin
        r.tag_data[i].valid = vld;
        r.tag_data[i].state = st;
        r.tag_data[i].tag   = tag;
      end
    end
    return r;
  endfunction

  task automatic clean_miss(input logic [63:0] a, input logic [3:0] way, input cache_state_e st,
                            input int stall_beat, input bit hold);
    miss_req_i = 1'b1; miss_addr_i = a; miss_way_i = way; fill_state_i = st;
    #1 chk("miss_gnt", 128'(miss_gnt_o), 128'(1));
    step();
    if (!hold) miss_req_i = 1'b0;
    chk("busy", 128'(busy_o), 128'(1));
    chk("gnt_while_busy", 128'(miss_gnt_o), 128'(0));
    chk("tag_rd_req", 128'(tag_req_o), 128'(1));
    chk("tag_rd_bits", 128'(tag_req_bits_o), 128'(exp_tag_rd(a, way)));
    tag_gnt_i = 1'b1; step(); tag_gnt_i = 1'b0;
    tag_rsp_bits_i = victim_rsp(way, 1'b0, Dirty, 52'h0);
    chk("tag_rd_drop", 128'(tag_req_o), 128'(0));
    step();
    chk("fill_ar_valid", 128'(mem_ar_valid_o), 128'(1));
    chk("fill_ar_addr", 128'(mem_ar_addr_o), 128'({a[63:6], 6'b0}));
    chk("no_wb_aw", 128'(mem_aw_valid_o), 128'(0));
    chk("no_wb_rd", 128'(data_req_o), 128'(0));
    mem_ar_ready_i = 1'b1; step(); mem_ar_ready_i = 1'b0;
    chk("ar_drop", 128'(mem_ar_valid_o), 128'(0));
    for (int k = 0; k < BEATS; k++) begin
      mem_r_valid_i = 1'b1; mem_r_data_i = 64'h100 + 64'(k); mem_r_last_i = (k == BEATS-1);
      step();
    end
    mem_r_valid_i = 1'b0; mem_r_last_i = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      chk("fill_wr_req", 128'(data_req_o), 128'(1));
      chk("fill_wr_bits", 128'(data_req_bits_o), 128'(exp_data(1'b1, a, way, k, 64'h100 + 64'(k))));
      if (k == stall_beat) begin
        repeat (3) begin
          step();
          chk("stall_req", 128'(data_req_o), 128'(1));
          chk("stall_bits", 128'(data_req_bits_o), 128'(exp_data(1'b1, a, way, k, 64'h100 + 64'(k))));
        end
      end
      data_gnt_i = 1'b1; step(); data_gnt_i = 1'b0;
    end
    chk("fill_wr_drop", 128'(data_req_o), 128'(0));
    chk("tag_wr_req", 128'(tag_req_o), 128'(1));
    chk("tag_wr_bits", 128'(tag_req_bits_o), 128'(exp_tag_wr(a, way, st)));
    tag_gnt_i = 1'b1; step(); tag_gnt_i = 1'b0;
    chk("done_pulse", 128'(miss_done_o), 128'(1));
    chk("done_idle", 128'(busy_o), 128'(0));
    chk("done_tag_drop", 128'(tag_req_o), 128'(0));
    chk("no_gnt_in_done", 128'(miss_gnt_o), 128'(0));
    step();
    chk("done_once", 128'(miss_done_o), 128'(0));
  endtask

  initial begin
    logic [63:0] a;
    logic [3:0]  way;
    logic [63:0] exp_d;

    rst_i = 1'b0;
    miss_req_i = 1'b0; miss_addr_i = '0; miss_way_i = '0; fill_state_i = Clean;
    tag_gnt_i = 1'b0; tag_rsp_bits_i = '0; data_gnt_i = 1'b0; data_rsp_bits_i = '0;
    mem_ar_ready_i = 1'b0; mem_r_valid_i = 1'b0; mem_r_data_i = '0; mem_r_last_i = 1'b0;
    mem_aw_ready_i = 1'b0; mem_w_ready_i = 1'b0; mem_b_valid_i = 1'b0;
    step(); step();
    miss_req_i = 1'b1;
    #1 chk_quiet("reset");
    miss_req_i = 1'b0;
    rst_i = 1'b1;
    step();

    // Clean miss, way 1, with a 3-cycle grant stall on fill beat 2.
    clean_miss(64'hABCD_0000_0000_1F48, 4'b0010, Exclusive, 2, 1'b0);

    // Dirty victim with tag 0x5A, W backpressure, fill that ends early after 3 beats.
    a = 64'h0000_0000_0042_3A80; way = 4'b0100;
    miss_req_i = 1'b1; miss_addr_i = a; miss_way_i = way; fill_state_i = Dirty;
    #1 step();
    miss_req_i = 1'b0;
    chk("d_tag_rd_bits", 128'(tag_req_bits_o), 128'(exp_tag_rd(a, way)));
    tag_gnt_i = 1'b1; step(); tag_gnt_i = 1'b0;
    tag_rsp_bits_i = victim_rsp(way, 1'b1, Dirty, 52'h5A);
    step();
    for (int k = 0; k < BEATS; k++) begin
      chk("wb_rd_req", 128'(data_req_o), 128'(1));
      chk("wb_rd_bits", 128'(data_req_bits_o), 128'(exp_data(1'b0, a, way, k, 64'h0)));
      data_gnt_i = 1'b1; step(); data_gnt_i = 1'b0;
      chk("wb_rd_drop", 128'(data_req_o), 128'(0));
      data_rsp_bits_i = {4{64'hBAD0}};
      data_rsp_bits_i.rd_data[2] = 64'hD000 + 64'(k);
      step();
    end
    chk("wb_aw_valid", 128'(mem_aw_valid_o), 128'(1));
    chk("wb_aw_addr", 128'(mem_aw_addr_o), 128'(64'h5_AA80));
    chk("wb_no_ar", 128'(mem_ar_valid_o), 128'(0));
    mem_aw_ready_i = 1'b1; step(); mem_aw_ready_i = 1'b0;
    chk("wb_aw_drop", 128'(mem_aw_valid_o), 128'(0));
    for (int k = 0; k < BEATS; k++) begin
      chk("wb_w_valid", 128'(mem_w_valid_o), 128'(1));
      chk("wb_w_data", 128'(mem_w_data_o), 128'(64'hD000 + 64'(k)));
      chk("wb_w_last", 128'(mem_w_last_o), 128'(k == BEATS-1));
      mem_w_ready_i = 1'b0; step();
      chk("wb_w_hold", 128'(mem_w_data_o), 128'(64'hD000 + 64'(k)));
      mem_w_ready_i = 1'b1; step(); mem_w_ready_i = 1'b0;
    end
    chk("wb_w_drop", 128'(mem_w_valid_o), 128'(0));
    mem_r_valid_i = 1'b1; mem_r_data_i = 64'hFFFF; mem_r_last_i = 1'b1;
    step();
    mem_r_valid_i = 1'b0; mem_r_last_i = 1'b0;
    chk("ar_waits_b0", 128'(mem_ar_valid_o), 128'(0));
    step();
    chk("ar_waits_b1", 128'(mem_ar_valid_o), 128'(0));
    mem_b_valid_i = 1'b1; step(); mem_b_valid_i = 1'b0;
    chk("d_ar_valid", 128'(mem_ar_valid_o), 128'(1));
    chk("d_ar_addr", 128'(mem_ar_addr_o), 128'(a));
    mem_ar_ready_i = 1'b1; step(); mem_ar_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_r_valid_i = 1'b1; mem_r_data_i = 64'hE000 + 64'(k); mem_r_last_i = (k == 2);
      step();
    end
    mem_r_valid_i = 1'b0; mem_r_last_i = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      exp_d = (k < 3) ? 64'hE000 + 64'(k) : 64'hD000 + 64'(k);
      chk("d_fill_bits", 128'(data_req_bits_o), 128'(exp_data(1'b1, a, way, k, exp_d)));
      data_gnt_i = 1'b1; step(); data_gnt_i = 1'b0;
    end
    chk("d_tag_wr_bits", 128'(tag_req_bits_o), 128'(exp_tag_wr(a, way, Dirty)));
    tag_gnt_i = 1'b1; step(); tag_gnt_i = 1'b0;
    chk("d_done", 128'(miss_done_o), 128'(1));
    step();

    // Reset while the fill is streaming in.
    a = 64'h0000_0000_0000_5000; way = 4'b1000;
    miss_req_i = 1'b1; miss_addr_i = a; miss_way_i = way; fill_state_i = Shared;
    #1 step();
    miss_req_i = 1'b0;
    tag_gnt_i = 1'b1; step(); tag_gnt_i = 1'b0;
    tag_rsp_bits_i = victim_rsp(way, 1'b1, Clean, 52'h3);
    step();
    mem_ar_ready_i = 1'b1; step(); mem_ar_ready_i = 1'b0;
    mem_r_valid_i = 1'b1; mem_r_data_i = 64'h55; mem_r_last_i = 1'b0;
    step(); step();
    chk("fill_busy", 128'(busy_o), 128'(1));
    rst_i = 1'b0;
    #1 chk_quiet("rst_async");
    step();
    chk_quiet("rst_held");
    mem_r_valid_i = 1'b0;
    rst_i = 1'b1;
    step();

    // Back-to-back misses with the request held high across completion.
    clean_miss(64'h0000_0001_2345_6040, 4'b0001, Shared, -1, 1'b1);
    chk("b2b_gnt_after_done", 128'(miss_gnt_o), 128'(1));
    clean_miss(64'h0000_0000_0000_0FC0, 4'b0100, Clean, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
